tt_um_serial_sub8: RTL



---
 rtl/tt_um_serial_sub8.sv | 112 +++++++++++
 1 files changed

// File: rtl/tt_um_serial_sub8.sv
// Bit-serial 8-bit unsigned subtractor: one full-subtractor cell plus a borrow
// flip-flop produce A - B LSB-first over 8 clocks, with borrow/zero/done status.
module tt_um_serial_sub8 (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Named state register so checkers can bind to it directly.
   state_t     state;

   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [7:0] sa;
   logic [7:0] sb;
   logic [7:0] sd;
   logic [7:0] res;
   logic       br;
   logic [2:0] cnt;
   logic       borrow_f;
   logic       zero_f;
   logic       done_f;
   logic       start_q;

   logic       load_a;
   logic       load_b;
   logic       start;
   logic       start_evt;
   logic       d;
   logic       br_next;
   logic [7:0] sd_next;

   assign load_a = uio_in[0];
   assign load_b = uio_in[1];
   assign start  = uio_in[2];

   wire unused_ok = &{1'b0, ena, uio_in[7:3]};

   // Rising edge of start only; the RUN check lives in the state case below.
   assign start_evt = start & ~start_q;

   assign d       = sa[0] ^ sb[0] ^ br;
   assign br_next = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
   assign sd_next = {d, sd[7:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op_a     <= 8'h00;
         op_b     <= 8'h00;
         sa       <= 8'h00;
         sb       <= 8'h00;
         sd       <= 8'h00;
         res      <= 8'h00;
         br       <= 1'b0;
         cnt      <= 3'd0;
         borrow_f <= 1'b0;
         zero_f   <= 1'b0;
         done_f   <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         start_q <= start;
         case (state)
            IDLE, DONE: begin
               if (load_a) op_a <= ui_in;
               if (load_b) op_b <= ui_in;
               // Operands captured here are the pre-edge values, so a load in
               // the same cycle only affects the following operation.
               if (start_evt) begin
                  sa     <= op_a;
                  sb     <= op_b;
                  br     <= 1'b0;
                  cnt    <= 3'd0;
                  done_f <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               sd  <= sd_next;
               sa  <= {1'b0, sa[7:1]};
               sb  <= {1'b0, sb[7:1]};
               br  <= br_next;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  res      <= sd_next;
                  borrow_f <= br_next;
                  zero_f   <= (sd_next == 8'h00);
                  done_f   <= 1'b1;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign uo_out  = res;
   assign uio_out = {(state == RUN), done_f, borrow_f, zero_f, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule
